// File: rtl/nn_host_driver_pkg.sv
// nn_host_driver_pkg: shared definitions for the NN host driver.
// Holds the status-register address, the run command word and the driver state type.
package nn_host_driver_pkg;
  localparam logic [15:0] STATUS_ADDR     = 16'hC000;
  localparam logic [31:0] STATUS_RUN_WORD = 32'h0000_0001;
  typedef enum logic [2:0] {
    IDLE, LOAD, START, ARM, WAIT, RADDR, RDATA, OUT
  } hd_state_t;
endpackage

// File: rtl/nn_host_driver.sv
// nn_host_driver: loads words into the accelerator memory map, starts a run,
// waits for it to finish and streams OUT_COUNT output-memory words to the host.
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready/cmd_addr/cmd_data/cmd_last   load-word stream in
//   nn_write_enable/nn_write_addr/nn_write_data      accelerator write port
//   nn_busy                                          accelerator busy
//   nn_read_addr/nn_read_data                        output-memory read (1-cycle latency)
//   res_valid/res_ready/res_data/res_last            result stream out
//   done                                             pulse after the last result is taken
module nn_host_driver
  import nn_host_driver_pkg::*;
#(
  parameter int MM_DEPTH  = 16,
  parameter int MM_SIZE   = 32,
  parameter int Q_SIZE    = 16,
  parameter int OUT_COUNT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [MM_DEPTH-1:0] cmd_addr,
  input  logic [MM_SIZE-1:0]  cmd_data,
  input  logic                cmd_last,
  output logic                nn_write_enable,
  output logic [MM_DEPTH-1:0] nn_write_addr,
  output logic [MM_SIZE-1:0]  nn_write_data,
  input  logic                nn_busy,
  output logic [MM_DEPTH-1:0] nn_read_addr,
  input  logic [Q_SIZE-1:0]   nn_read_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [Q_SIZE-1:0]   res_data,
  output logic                res_last,
  output logic                done
);
  hd_state_t  state;
  logic [7:0] idx;
  logic       arm_cnt;
  logic       accept;
  logic       idx_last;
  // Gated by reset so every output reads 0 while reset is held.
  assign cmd_ready    = reset & (state == IDLE || state == LOAD) & ~nn_busy;
  assign accept       = cmd_valid & cmd_ready;
  assign idx_last     = idx == 8'(OUT_COUNT - 1);
  assign nn_read_addr = (state == RADDR || state == RDATA) ? MM_DEPTH'(idx) : '0;
  assign res_last     = res_valid & idx_last;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      idx             <= '0;
      arm_cnt         <= 1'b0;
      nn_write_enable <= 1'b0;
      nn_write_addr   <= '0;
      nn_write_data   <= '0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      done            <= 1'b0;
    end else begin
      nn_write_enable <= 1'b0;
      nn_write_addr   <= '0;
      nn_write_data   <= '0;
      done            <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            nn_write_enable <= 1'b1;
            nn_write_addr   <= cmd_addr;
            nn_write_data   <= cmd_data;
          end
          if (accept && cmd_last) state <= START;
          else if (cmd_valid) state <= LOAD;
        end
        START: if (!nn_busy) begin
          nn_write_enable <= 1'b1;
          nn_write_addr   <= MM_DEPTH'(STATUS_ADDR);
          nn_write_data   <= MM_SIZE'(STATUS_RUN_WORD);
          arm_cnt         <= 1'b0;
          state           <= ARM;
        end
        // Fixed two-cycle window lets the accelerator raise busy before WAIT samples it.
        ARM: begin
          arm_cnt <= 1'b1;
          if (arm_cnt) state <= WAIT;
        end
        WAIT: if (!nn_busy) begin
          idx   <= '0;
          state <= RADDR;
        end
        RADDR: state <= RDATA;
        RDATA: begin
          res_data  <= nn_read_data;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (res_ready) begin
          res_valid <= 1'b0;
          if (idx_last) begin
            done  <= 1'b1;
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= RADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
